// File: rtl/matrix_scan_pkg.sv
// Shared geometry, scan state encoding and row-select helper for the LED matrix scanner.
package matrix_scan_pkg;

    localparam int MATRIX_ROWS = 16;
    localparam int MATRIX_COLS = 8;
    localparam int ROW_W       = $clog2(MATRIX_ROWS);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    typedef logic [MATRIX_ROWS-1:0][MATRIX_COLS-1:0] frame_t;

    // Active-low one-hot select: only the addressed row is pulled low.
    function automatic logic [MATRIX_ROWS-1:0] row_select(input logic [ROW_W-1:0] row);
        return ~(MATRIX_ROWS'(1) << row);
    endfunction

endpackage

// File: rtl/matrix_scan_row_capture.sv
// Captures the row stream from the game FSM into a shadow frame and flags complete frames.
module row_capture
    import matrix_scan_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROW_W-1:0]       address,
    input  logic [MATRIX_COLS-1:0] print,
    input  logic                   commit,
    output frame_t                 shadow,
    output logic                   frame_pending
);

    logic [ROW_W-1:0] expected;
    logic             hit;
    logic             restart;
    logic             set_pending;

    // A stray row 0 restarts the frame so a resynchronising source loses at most one frame.
    always_comb begin
        hit         = (address == expected);
        restart     = !hit && (address == '0);
        set_pending = hit && (expected == ROW_W'(MATRIX_ROWS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow        <= '0;
            expected      <= '0;
            frame_pending <= 1'b0;
        end else begin
            if (hit || restart) begin
                shadow[address] <= print;
            end

            if (hit) begin
                expected <= expected + 1'b1;
            end else if (restart) begin
                expected <= ROW_W'(1);
            end else begin
                expected <= '0;
            end

            // A frame finishing on the commit cycle must not be lost.
            if (set_pending) begin
                frame_pending <= 1'b1;
            end else if (commit) begin
                frame_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/matrix_scan.sv
// LED matrix scanner: double-buffered 16x8 display driven one row at a time with blanking gaps.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_BLANK | all rows off, columns off; frame commit happens on exit
// ST_SHOW  | scan row driven low, col shows display[scan row]
module matrix_scan
    import matrix_scan_pkg::*;
#(
    parameter int DWELL = 1000,
    parameter int BLANK = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROW_W-1:0]       address,
    input  logic [MATRIX_COLS-1:0] print,
    output logic [MATRIX_ROWS-1:0] row_sel,
    output logic [MATRIX_COLS-1:0] col,
    output logic                   frame_tick
);

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);

    scan_state_t            state, state_nxt;
    logic [15:0]            dwell_cnt, dwell_cnt_nxt;
    logic [ROW_W-1:0]       scan_row, scan_row_nxt;
    logic [MATRIX_ROWS-1:0] row_sel_nxt;
    logic [MATRIX_COLS-1:0] col_nxt;
    logic                   commit;
    logic                   frame_pending;
    frame_t                 shadow;
    frame_t                 display;

    row_capture u_capture (
        .clk           (clk),
        .rst           (rst),
        .address       (address),
        .print         (print),
        .commit        (commit),
        .shadow        (shadow),
        .frame_pending (frame_pending)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_BLANK;
            dwell_cnt  <= '0;
            scan_row   <= '0;
            row_sel    <= '1;
            col        <= '0;
            frame_tick <= 1'b0;
            display    <= '0;
        end else begin
            state      <= state_nxt;
            dwell_cnt  <= dwell_cnt_nxt;
            scan_row   <= scan_row_nxt;
            row_sel    <= row_sel_nxt;
            col        <= col_nxt;
            frame_tick <= commit;
            if (commit) begin
                display <= shadow;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        dwell_cnt_nxt = dwell_cnt + 16'd1;
        scan_row_nxt  = scan_row;
        row_sel_nxt   = row_sel;
        col_nxt       = col;
        commit        = 1'b0;

        case (state)
            ST_BLANK: begin
                if (dwell_cnt == BLANK_LAST) begin
                    state_nxt     = ST_SHOW;
                    dwell_cnt_nxt = '0;
                    commit        = (scan_row == '0) && frame_pending;
                    row_sel_nxt   = row_select(scan_row);
                    // Row 0 of a freshly committed frame comes straight from the shadow copy.
                    col_nxt       = commit ? shadow[scan_row] : display[scan_row];
                end
            end
            ST_SHOW: begin
                if (dwell_cnt == DWELL_LAST) begin
                    state_nxt     = ST_BLANK;
                    dwell_cnt_nxt = '0;
                    scan_row_nxt  = scan_row + 1'b1;
                    row_sel_nxt   = '1;
                    col_nxt       = '0;
                end
            end
            default: begin
                state_nxt     = ST_BLANK;
                dwell_cnt_nxt = '0;
                row_sel_nxt   = '1;
                col_nxt       = '0;
            end
        endcase
    end

endmodule
